// File: rtl/display_scanner.sv
// Time-multiplexes three active-low 7-segment patterns onto one shared bus with
// per-slot dead time, per-frame input snapshot and optional leading-zero blanking.
module display_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lz_en,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  output logic [2:0] transistor,
  output logic [6:0] d7sp,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0]  ZERO  = 7'b0000001;
  localparam logic [6:0]  OFF   = 7'h7F;

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       digit;
  logic [6:0]       f1, f2, f3;
  logic [2:0]       sel;
  logic [6:0]       seg_q;
  logic             tick_q;

  logic       hide3, hide2, slot_end, frame_end, frame_start;
  logic [2:0] sel_c;
  logic [6:0] seg_c;

  // Next output value, decoded from the current counter state and frame registers.
  always_comb begin
    hide3       = lz_en && (f3 == ZERO);
    hide2       = hide3 && (f2 == ZERO);
    slot_end    = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    frame_end   = slot_end && (digit == 2'd2);
    frame_start = (slot_cnt == '0) && (digit == 2'd0);
    sel_c       = 3'b000;
    seg_c       = OFF;
    if (slot_cnt >= CNT_W'(BLANK_CYCLES)) begin
      case (digit)
        2'd0: begin
          sel_c = 3'b001;
          seg_c = f1;
        end
        2'd1: begin
          if (!hide2) begin
            sel_c = 3'b010;
            seg_c = f2;
          end
        end
        2'd2: begin
          if (!hide3) begin
            sel_c = 3'b100;
            seg_c = f3;
          end
        end
        default: begin
          sel_c = 3'b000;
          seg_c = OFF;
        end
      endcase
    end
  end

  // Slot/digit counters, frame snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
      f1       <= OFF;
      f2       <= OFF;
      f3       <= OFF;
      sel      <= 3'b000;
      seg_q    <= OFF;
      tick_q   <= 1'b0;
    end else if (!en) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
      sel      <= 3'b000;
      seg_q    <= OFF;
      tick_q   <= 1'b0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
      if (frame_start) begin
        f1 <= seg1;
        f2 <= seg2;
        f3 <= seg3;
      end
      sel    <= sel_c;
      seg_q  <= seg_c;
      tick_q <= frame_end;
    end
  end

  assign transistor = SEL_ACTIVE_LOW ? ~sel : sel;
  assign d7sp       = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: constant vectors, directed corner
// sequences and random stimulus against a frame-position reference model.
module tb_display_scanner;

  localparam int unsigned SD = 8;
  localparam int unsigned BL = 2;
  localparam int unsigned FRAME = 3 * SD;
  localparam logic [6:0] ZERO = 7'h01, OFF = 7'h7F;
  localparam logic [6:0] P1 = 7'h4F, P2 = 7'h12, P3 = 7'h06;
  localparam logic [6:0] P4 = 7'h4C, P5 = 7'h24, P7 = 7'h0F;

  logic       clk = 1'b0;
  logic       rst, en, lz_en;
  logic [6:0] seg1, seg2, seg3;
  logic [2:0] tr, tr_n;
  logic [6:0] d7, d7_n;
  logic       ft, ft_n;

  always #5 clk = ~clk;

  display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .SEL_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .transistor(tr), .d7sp(d7), .frame_tick(ft));

  display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .SEL_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .transistor(tr_n), .d7sp(d7_n), .frame_tick(ft_n));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame plus the snapshot of the three digits.
  int         pos;
  logic [6:0] snap [3];
  logic [2:0] m_sel;
  logic [6:0] m_seg;
  logic       m_tick;

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < 3; i++) snap[i] = OFF;
    m_sel = 3'b000; m_seg = OFF; m_tick = 1'b0;
  endtask

  task automatic model_edge();
    int d, s;
    logic h2, h3, hid, vis;
    if (!en) begin
      pos = 0;
      m_sel = 3'b000; m_seg = OFF; m_tick = 1'b0;
    end else begin
      d = pos / SD;
      s = pos % SD;
      h3 = lz_en && (snap[2] == ZERO);
      h2 = h3 && (snap[1] == ZERO);
      hid = (d == 2) ? h3 : (d == 1) ? h2 : 1'b0;
      vis = (s >= BL) && !hid;
      m_sel  = vis ? 3'(1 << d) : 3'b000;
      m_seg  = vis ? snap[d] : OFF;
      m_tick = (pos == FRAME - 1);
      if (pos == 0) begin
        snap[0] = seg1; snap[1] = seg2; snap[2] = seg3;
      end
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic check_model();
    logic [2:0] inv;
    inv = ~m_sel;
    check("model transistor", tr, m_sel);
    check("model transistor_n", tr_n, inv);
    check("model d7sp", d7, m_seg);
    check("model d7sp_n", d7_n, m_seg);
    check("model frame_tick", ft, m_tick);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1 check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    check_model();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       lz;
    logic [6:0] s1, s2, s3;
    int         n;
    logic [2:0] tr;
    logic [6:0] d7;
    logic       ft;
  } vec_t;

  vec_t vecs [$];
  logic [6:0] pats [11];

  initial begin
    logic [2:0] inv;
    vec_t v;
    rst = 1'b0; en = 1'b1; lz_en = 1'b0;
    seg1 = P1; seg2 = P2; seg3 = P3;
    pats = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04, 7'h55};

    // Outputs after n enabled edges from reset, inputs constant.
    vecs.push_back('{1'b0, P1, P2, P3,  1, 3'b000, OFF,  1'b0});
    vecs.push_back('{1'b0, P1, P2, P3,  2, 3'b000, OFF,  1'b0});
    vecs.push_back('{1'b0, P1, P2, P3,  3, 3'b001, P1,   1'b0});
    vecs.push_back('{1'b0, P1, P2, P3,  8, 3'b001, P1,   1'b0});
    vecs.push_back('{1'b0, P1, P2, P3,  9, 3'b000, OFF,  1'b0});
    vecs.push_back('{1'b0, P1, P2, P3, 11, 3'b010, P2,   1'b0});
    vecs.push_back('{1'b0, P1, P2, P3, 24, 3'b100, P3,   1'b1});
    vecs.push_back('{1'b0, P1, P2, P3, 25, 3'b000, OFF,  1'b0});
    vecs.push_back('{1'b1, P7, ZERO, ZERO, 12, 3'b000, OFF, 1'b0});
    vecs.push_back('{1'b1, P7, ZERO, ZERO, 20, 3'b000, OFF, 1'b0});
    vecs.push_back('{1'b1, P7, ZERO, ZERO,  5, 3'b001, P7,  1'b0});
    vecs.push_back('{1'b1, P7, P4, ZERO, 12, 3'b010, P4,   1'b0});
    vecs.push_back('{1'b1, P7, P4, ZERO, 24, 3'b000, OFF,  1'b1});
    vecs.push_back('{1'b1, ZERO, ZERO, ZERO, 3, 3'b001, ZERO, 1'b0});
    vecs.push_back('{1'b0, P1, P2, ZERO, 20, 3'b100, ZERO, 1'b0});
    vecs.push_back('{1'b0, 7'h55, P2, P3, 3, 3'b001, 7'h55, 1'b0});

    foreach (vecs[i]) begin
      v = vecs[i];
      en = 1'b1; lz_en = v.lz; seg1 = v.s1; seg2 = v.s2; seg3 = v.s3;
      do_reset();
      repeat (v.n) cycle();
      inv = ~v.tr;
      check($sformatf("vec%0d transistor", i), tr, v.tr);
      check($sformatf("vec%0d transistor_n", i), tr_n, inv);
      check($sformatf("vec%0d d7sp", i), d7, v.d7);
      check($sformatf("vec%0d frame_tick", i), ft, v.ft);
    end

    // Snapshot coherence: seg1 changes during the tens slot.
    lz_en = 1'b0; seg1 = P1; seg2 = P2; seg3 = P3;
    do_reset();
    repeat (10) cycle();
    seg1 = P5;
    repeat (16) cycle();
    check("snap blank", d7, OFF);
    cycle();
    check("snap new units", d7, P5);

    // Enable gating during the tens visible window.
    seg1 = P1;
    do_reset();
    repeat (11) cycle();
    check("gate pre tr", tr, 3'b010);
    en = 1'b0;
    cycle();
    check("gate off tr", tr, 3'b000);
    check("gate off d7sp", d7, OFF);
    check("gate off tick", ft, 1'b0);
    repeat (3) cycle();
    en = 1'b1;
    repeat (2) cycle();
    check("gate reen blank", tr, 3'b000);
    cycle();
    check("gate reen tr", tr, 3'b001);
    check("gate reen d7sp", d7, P1);

    // Asynchronous reset between edges mid-slot.
    repeat (12) cycle();
    #2 rst = 1'b1;
    #1 model_reset();
    check("async tr", tr, 3'b000);
    check("async tr_n", tr_n, 3'b111);
    check("async d7sp", d7, OFF);
    check("async tick", ft, 1'b0);
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    check("async post blank", tr, 3'b000);
    cycle();
    check("async post tr", tr, 3'b001);
    check("async post d7sp", d7, P1);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 39) == 0) lz_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) seg1 = pats[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) seg2 = ($urandom_range(0, 1) == 1) ? ZERO : pats[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) seg3 = ($urandom_range(0, 1) == 1) ? ZERO : pats[$urandom_range(0, 10)];
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
